dc_blocker: RTL and testbench
=============================

DC_BLOCKER -- requirements
Module: dc_blocker

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width of each channel.
REQ-002 SHALL have parameter SHIFT, default 8, pole shift: leak per sample = acc >>> SHIFT.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning input sample pair present.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning block can accept a pair.
REQ-007 SHALL have port in_l, input, WIDTH bits, unsigned left sample.
REQ-008 SHALL have port in_r, input, WIDTH bits, unsigned right sample.
REQ-009 SHALL have port out_valid, output, 1 bit, one-cycle pulse when results are updated.
REQ-010 SHALL have port out_l, output, WIDTH bits, signed filtered left result.
REQ-011 SHALL have port out_r, output, WIDTH bits, signed filtered right result.

Function
REQ-012 SHALL implement a first-order high-pass per channel; state per channel: x_prev (WIDTH unsigned) and acc (signed, WIDTH+SHIFT+2 bits).
REQ-013 SHALL use a four-state FSM: IDLE, CALC_L, CALC_R, OUTPUT; in_ready = 1 only in IDLE.
REQ-014 Handshake: a pair is accepted when in_valid & in_ready at a clock edge; in_l/in_r are latched and the FSM moves IDLE->CALC_L.
REQ-015 CALC_L: d = in_l - x_prev_l as signed WIDTH+1; acc_l <= acc_l + (d <<< SHIFT) - (acc_l >>> SHIFT), arithmetic shift; x_prev_l <= in_l; then CALC_R.
REQ-016 CALC_R: identical update for the right channel; then OUTPUT.
REQ-017 OUTPUT: out_l/out_r <= acc >>> SHIFT reduced to WIDTH bits per REQ-025/026; out_valid = 1 for this one cycle; then IDLE.
REQ-018 Latency: pair accepted at edge N -> out_valid high in the cycle after edge N+3; maximum throughput one pair per 4 cycles.
REQ-019 Priming: first accepted pair after reset loads x_prev_l/x_prev_r with the samples and leaves acc at 0, so the first output is 0, 0 with no start-up step; primed flag set afterwards.
REQ-020 in_valid asserted outside IDLE is ignored and not latched; a held in_valid is accepted on return to IDLE.
REQ-021 out_l/out_r hold their value between out_valid pulses.

Reset
REQ-022 reset asserted SHALL immediately force: state IDLE, in_ready 1 (after release), out_valid 0, out_l/out_r 0, acc 0, x_prev 0, primed 0.
REQ-023 Reset mid-operation (any non-IDLE state) SHALL abort the sample with no out_valid pulse; the next accepted pair primes again.
REQ-024 No output SHALL depend on uninitialised state after reset release.

Configuration
REQ-025 With macro DC_BLOCKER_SAT_EN defined, each output SHALL clamp acc >>> SHIFT to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-026 Without DC_BLOCKER_SAT_EN, each output SHALL be the low WIDTH bits of acc >>> SHIFT (two's-complement wrap); timing is identical in both builds.

Verification (WIDTH=16, SHIFT=8)
REQ-027 Reset, then accept pair (0x8000, 0x8000) -> out_valid 3 cycles after acceptance edge, out_l = out_r = 0x0000.
REQ-028 After REQ-027, accept (0x9000, 0x8000) -> out_l = 0x1000, out_r = 0x0000; then accept (0x9000, 0x8000) again -> out_l = 0x0FF0, out_r = 0x0000.
REQ-029 Prime with (0x0000, 0x0000), then accept (0xFFFF, 0x0000) -> out_l = 0x7FFF with DC_BLOCKER_SAT_EN; out_l = 0xFFFF without it.
REQ-030 Hold in_valid high continuously with changing data -> in_ready high exactly 1 cycle in 4, one out_valid per accepted pair, no pair skipped or duplicated.
REQ-031 Assert reset during CALC_R -> out_valid never pulses for that pair, outputs read 0; next pair (0x1234, 0x4321) outputs 0, 0 (re-primed).

Source files
------------

// File: rtl/dc_blocker.sv
// dc_blocker: two-channel first-order DC-blocking (high-pass) filter.
//
// Each accepted sample pair is processed over four cycles: IDLE (accept),
// CALC_L, CALC_R, OUTPUT. Per channel:
//   d   = in - x_prev                         (signed, WIDTH+1 bits)
//   acc = acc + (d <<< SHIFT) - (acc >>> SHIFT)
//   out = acc >>> SHIFT reduced to WIDTH bits
// The first pair after reset only primes x_prev, so the first output is 0.
//
// Optional feature: define DC_BLOCKER_SAT_EN to clamp each output to the
// signed WIDTH-bit range instead of taking the low WIDTH bits (wrap).
//
// Ports:
//   clk        single clock, rising-edge
//   reset      asynchronous active-high reset
//   in_valid   input pair present
//   in_ready   block can accept a pair (high only in IDLE)
//   in_l/in_r  unsigned input samples, WIDTH bits
//   out_valid  one-cycle pulse when out_l/out_r are updated
//   out_l/out_r signed filtered results, WIDTH bits, held between pulses
module dc_blocker #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_l,
  input  logic [WIDTH-1:0] in_r,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_l,
  output logic [WIDTH-1:0] out_r
);

  localparam int unsigned ACC_W = WIDTH + SHIFT + 2;
  localparam int unsigned D_W   = WIDTH + 1;
  // Bits of acc at and above the output sign bit; all equal means no overflow.
  localparam int unsigned HI_W  = ACC_W - SHIFT - WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_L = 2'd1,
    CALC_R = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         in_l_q, in_l_d, in_r_q, in_r_d;
  logic [WIDTH-1:0]         x_prev_l_q, x_prev_l_d, x_prev_r_q, x_prev_r_d;
  logic signed [ACC_W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic                     primed_q, primed_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [WIDTH-1:0]         out_l_q, out_l_d, out_r_q, out_r_d;

  // Shared update datapath, steered to the channel being computed
  logic                     ch_r;
  logic [WIDTH-1:0]         cur_in, cur_x;
  logic signed [ACC_W-1:0]  cur_acc, diff_ext, acc_next;
  logic signed [D_W-1:0]    diff;

  always_comb begin
    ch_r     = (state_q == CALC_R);
    cur_in   = ch_r ? in_r_q     : in_l_q;
    cur_x    = ch_r ? x_prev_r_q : x_prev_l_q;
    cur_acc  = ch_r ? acc_r_q    : acc_l_q;
    diff     = $signed({1'b0, cur_in}) - $signed({1'b0, cur_x});
    diff_ext = ACC_W'(diff);
    acc_next = cur_acc + (diff_ext <<< SHIFT) - (cur_acc >>> SHIFT);
  end

  // Reduce acc >>> SHIFT to WIDTH bits (wrap by default, clamp if enabled)
  logic [WIDTH-1:0] red_l, red_r;

  always_comb begin
    red_l = acc_l_q[SHIFT +: WIDTH];
    red_r = acc_r_q[SHIFT +: WIDTH];
`ifdef DC_BLOCKER_SAT_EN
    if (!((&acc_l_q[ACC_W-1 -: HI_W]) || !(|acc_l_q[ACC_W-1 -: HI_W]))) begin
      red_l = acc_l_q[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    if (!((&acc_r_q[ACC_W-1 -: HI_W]) || !(|acc_r_q[ACC_W-1 -: HI_W]))) begin
      red_r = acc_r_q[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Next-state and register-input logic
  always_comb begin
    state_d     = state_q;
    in_l_d      = in_l_q;
    in_r_d      = in_r_q;
    x_prev_l_d  = x_prev_l_q;
    x_prev_r_d  = x_prev_r_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_l_d  = in_l;
          in_r_d  = in_r;
          state_d = CALC_L;
        end
      end
      CALC_L: begin
        // Unprimed: only load x_prev so there is no start-up step
        if (primed_q) acc_l_d = acc_next;
        x_prev_l_d = in_l_q;
        state_d    = CALC_R;
      end
      CALC_R: begin
        if (primed_q) acc_r_d = acc_next;
        x_prev_r_d = in_r_q;
        state_d    = OUTPUT;
      end
      OUTPUT: begin
        out_l_d     = red_l;
        out_r_d     = red_r;
        out_valid_d = 1'b1;
        primed_d    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_l_q      <= '0;
      in_r_q      <= '0;
      x_prev_l_q  <= '0;
      x_prev_r_q  <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      primed_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_l_q      <= in_l_d;
      in_r_q      <= in_r_d;
      x_prev_l_q  <= x_prev_l_d;
      x_prev_r_q  <= x_prev_r_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      primed_q    <= primed_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_l     = out_l_q;
  assign out_r     = out_r_q;

endmodule

// File: tb/tb_dc_blocker.sv
// Self-checking bench for dc_blocker (WIDTH=16, SHIFT=8) with a
// behavioural model of the high-pass recurrence in plain integer arithmetic.
module tb_dc_blocker;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHIFT = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_l, in_r;
  logic             out_valid;
  logic [WIDTH-1:0] out_l, out_r;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit          m_primed;
  longint      m_xl, m_xr, m_accl, m_accr;
  logic [15:0] exp_l, exp_r;

  dc_blocker #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_l     (in_l),
    .in_r     (in_r),
    .out_valid(out_valid),
    .out_l    (out_l),
    .out_r    (out_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint a);
    longint q;
    q = a / 256;
    if ((a % 256 != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] reduce(input longint acc);
    longint y;
    y = floor_div(acc);
`ifdef DC_BLOCKER_SAT_EN
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
`endif
    return y[15:0];
  endfunction

  task automatic model_reset();
    m_primed = 1'b0;
    m_xl = 0; m_xr = 0; m_accl = 0; m_accr = 0;
  endtask

  // y[n] scaled by 256: acc += 256*(x - x_prev) - floor(acc/256)
  task automatic model_step(input logic [15:0] l, input logic [15:0] r);
    if (m_primed) begin
      m_accl = m_accl + (longint'(l) - m_xl) * 256 - floor_div(m_accl);
      m_accr = m_accr + (longint'(r) - m_xr) * 256 - floor_div(m_accr);
    end
    m_xl = longint'(l);
    m_xr = longint'(r);
    m_primed = 1'b1;
    exp_l = reduce(m_accl);
    exp_r = reduce(m_accr);
  endtask

  // Offer one pair, then check the pulse timing and results against the model
  task automatic send(input logic [15:0] l, input logic [15:0] r, input string tag);
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_l = l;
    in_r = r;
    model_step(l, r);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_l = 16'($urandom);
    in_r = 16'($urandom);
    repeat (3) begin
      @(negedge clk);
      check({tag, "_early"}, 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_l"}, 32'(out_l), 32'(exp_l));
    check({tag, "_r"}, 32'(out_r), 32'(exp_r));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_l", 32'(out_l), 32'd0);
    check("rst_r", 32'(out_r), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] lv, rv;
    int unsigned pick;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_l     = '0;
    in_r     = '0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset values and first-pair priming
    do_reset();
    send(16'h8000, 16'h8000, "prime");
    check("prime_l_const", 32'(out_l), 32'h0000);
    check("prime_r_const", 32'(out_r), 32'h0000);

    // Step response: first step, then one leak
    send(16'h9000, 16'h8000, "step1");
    check("step1_l_const", 32'(out_l), 32'h1000);
    check("step1_r_const", 32'(out_r), 32'h0000);
    send(16'h9000, 16'h8000, "step2");
    check("step2_l_const", 32'(out_l), 32'h0FF0);
    check("step2_r_const", 32'(out_r), 32'h0000);

    // Output held between pulses
    repeat (2) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd0);
      check("hold_l", 32'(out_l), 32'h0FF0);
    end

    // Full-scale step: saturate vs wrap
    do_reset();
    send(16'h0000, 16'h0000, "fs_prime");
    send(16'hFFFF, 16'h0000, "fs_step");
`ifdef DC_BLOCKER_SAT_EN
    check("fs_l_const", 32'(out_l), 32'h7FFF);
`else
    check("fs_l_const", 32'(out_l), 32'hFFFF);
`endif
    check("fs_r_const", 32'(out_r), 32'h0000);

    // Random pairs with random gaps, extremes mixed in
    for (int i = 0; i < 24; i++) begin
      pick = $urandom_range(0, 5);
      lv = (pick == 0) ? 16'hFFFF : (pick == 1) ? 16'h0000 : 16'($urandom);
      rv = (pick == 2) ? 16'hFFFF : (pick == 3) ? 16'h0000 : 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(lv, rv, "rand");
    end

    // Continuous in_valid: ready one cycle in four, one pulse per pair
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("stream_ready", 32'(in_ready), 32'd1);
      if (k > 0) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_l", 32'(out_l), 32'(exp_l));
        check("stream_r", 32'(out_r), 32'(exp_r));
      end else begin
        check("stream_valid0", 32'(out_valid), 32'd0);
      end
      lv = 16'($urandom);
      rv = 16'($urandom);
      in_valid = 1'b1;
      in_l = lv;
      in_r = rv;
      model_step(lv, rv);
      repeat (3) begin
        @(negedge clk);
        check("stream_busy", 32'(in_ready), 32'd0);
        check("stream_nopulse", 32'(out_valid), 32'd0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("stream_last_valid", 32'(out_valid), 32'd1);
    check("stream_last_l", 32'(out_l), 32'(exp_l));
    check("stream_last_r", 32'(out_r), 32'(exp_r));

    // Reset during CALC_R aborts the pair; next pair re-primes
    @(negedge clk);
    check("abort_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_l = 16'h5555;
    in_r = 16'hAAAA;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_l", 32'(out_l), 32'd0);
    check("abort_r", 32'(out_r), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_nopulse", 32'(out_valid), 32'd0);
    end
    send(16'h1234, 16'h4321, "reprime");
    check("reprime_l_const", 32'(out_l), 32'h0000);
    check("reprime_r_const", 32'(out_r), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
